// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 BCM scan engine.
//   state_t        : scan FSM states (SHIFT -> LATCH -> DISPLAY [-> GUARD])
//   GUARD_CYCLES   : dark cycles inserted on a row change when the ghost guard is built in
//   plane_weight() : display cycles for a bit-plane (base << plane)
//   color_slice_lo(): low bit of channel/component slice in the packed {B,G,R} pixel word
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_SHIFT   = 2'd0,
    ST_LATCH   = 2'd1,
    ST_DISPLAY = 2'd2,
    ST_GUARD   = 2'd3
  } state_t;

  localparam int GUARD_CYCLES = 2;

  function automatic int plane_weight(input int base, input int plane);
    return base << plane;
  endfunction

  // comp: 0 = R, 1 = G, 2 = B; channel c holds the c-th 3*bpp slice.
  function automatic int color_slice_lo(input int chan, input int comp, input int bpp);
    return (chan * 3 + comp) * bpp;
  endfunction

endpackage

// File: rtl/hub75_bcm_scan_if.sv
// Framebuffer read bus between the scan engine and a registered pixel RAM.
//   fb_x   : column address (driven by master)
//   fb_y   : row address within a channel (driven by master)
//   fb_rgb : pixel data for all channels, valid one cycle after the address
//            (driven by slave); channel c is the c-th 3*BPP slice, packed {B,G,R}.
// There is no handshake: the RAM answers every address with fixed one-cycle
// latency and the master never stalls, so no valid/ready pair exists.
interface hub75_bcm_scan_if #(
  parameter int COLS     = 64,
  parameter int ROWS     = 32,
  parameter int CHANNELS = 2,
  parameter int BPP      = 8
);
  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [XW-1:0]            fb_x;
  logic [YW-1:0]            fb_y;
  logic [CHANNELS*3*BPP-1:0] fb_rgb;

  modport master (output fb_x, output fb_y, input  fb_rgb);
  modport slave  (input  fb_x, input  fb_y, output fb_rgb);
endinterface

// File: rtl/hub75_plane_timer.sv
// Loadable down-counter timing DISPLAY and GUARD intervals.
//   clk, rst_n : clock, asynchronous active-low reset
//   load/value : load the counter with the interval length (>= 1)
//   done       : high during the last cycle of the interval (counter == 1)
// Loading N gives exactly N cycles with the counter in 1..N after the load.
module hub75_plane_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == W'(1));
endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 scan engine with binary-coded-modulation colour depth.
// Per row and bit-plane: shift COLS pixels of the plane into the panel, latch,
// then light the row for BASE<<plane cycles. Planes run 0..BPP-1, then the row
// advances (wrapping at ROWS).
// Ports:
//   clk, rst_n  : pixel clock, asynchronous active-low reset
//   fb          : framebuffer read bus (master side)
//   rgb         : plane bit per colour per channel, {B,G,R} per channel
//   sclk, latch : panel shift clock and latch strobe
//   blank       : panel output disable (high = dark)
//   addry       : panel row address, only updated on the latch cycle
//   frame_start : one-cycle pulse on the first SHIFT cycle of row 0 plane 0
//   dbg_state   : internal FSM state; it runs one cycle ahead of the outputs
// Optional build macro HUB75_GHOST_GUARD_EN: adds a 2-cycle dark GUARD state
// after the last plane of every row.
module hub75_bcm_scan
  import hub75_pkg::*;
#(
  parameter int  COLS     = 64,
  parameter int  ROWS     = 32,
  parameter int  CHANNELS = 2,
  parameter int  BPP      = 8,
  parameter int  BASE     = 4,
  localparam int YW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hub75_bcm_scan_if.master      fb,
  output logic [CHANNELS*3-1:0] rgb,
  output logic                  sclk,
  output logic                  latch,
  output logic                  blank,
  output logic [YW-1:0]         addry,
  output logic                  frame_start,
  output state_t                dbg_state
);
  localparam int XW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PW  = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int TCW = $clog2(2 * COLS + 2);
  localparam int DW  = $clog2(BASE << (BPP - 1)) + 1;
  // The guard interval needs at least 2 bits even in degenerate configs.
  localparam int TW  = (DW < 2) ? 2 : DW;

  localparam logic [TCW-1:0] T_LAST     = TCW'(2 * COLS + 1);
  localparam logic [TCW-1:0] T_LAST_PIX = TCW'(2 * COLS);
  localparam logic [PW-1:0]  PLANE_LAST = PW'(BPP - 1);
  localparam logic [YW-1:0]  ROW_LAST   = YW'(ROWS - 1);

  // The FSM below leads the panel outputs by one cycle: every output is a
  // register loaded from the current state, so the panel sees state k during
  // cycle k+1. Reset therefore parks at SHIFT t=0 and the first clock edge
  // presents that cycle, frame_start included.
  state_t          state_q, state_d;
  logic [TCW-1:0]  t_q, t_d;
  logic [PW-1:0]   plane_q, plane_d;
  logic [YW-1:0]   row_q, row_d;
  logic            tmr_load;
  logic [TW-1:0]   tmr_value;
  logic            tmr_done;
  logic [CHANNELS*3-1:0] rgb_sample;
  logic            rgb_take;
  logic            last_plane;

  assign dbg_state  = state_q;
  assign last_plane = (plane_q == PLANE_LAST);

  hub75_plane_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SHIFT;
      t_q     <= '0;
      plane_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      plane_q <= plane_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    plane_d   = plane_q;
    row_d     = row_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      ST_SHIFT: begin
        if (t_q == T_LAST) begin
          state_d = ST_LATCH;
          t_d     = '0;
        end else begin
          t_d = t_q + TCW'(1);
        end
      end
      ST_LATCH: begin
        state_d   = ST_DISPLAY;
        tmr_load  = 1'b1;
        tmr_value = TW'(plane_weight(BASE, int'(plane_q)));
      end
      ST_DISPLAY: begin
        if (tmr_done) begin
          state_d = ST_SHIFT;
          if (last_plane) begin
            plane_d = '0;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + YW'(1);
`ifdef HUB75_GHOST_GUARD_EN
            state_d   = ST_GUARD;
            tmr_load  = 1'b1;
            tmr_value = TW'(GUARD_CYCLES);
`endif
          end else begin
            plane_d = plane_q + PW'(1);
          end
        end
      end
      ST_GUARD: begin
`ifdef HUB75_GHOST_GUARD_EN
        if (tmr_done) state_d = ST_SHIFT;
`else
        state_d = ST_SHIFT;
`endif
      end
      default: state_d = ST_SHIFT;
    endcase
  end

  // Pixel x is addressed on t=2x, arrives on t=2x+1, and is captured at the
  // end of internal t=2x+2 so it appears on the pins at t=2x+2.
  always_comb begin
    rgb_sample = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < 3; k++) begin
        logic [BPP-1:0] comp;
        comp = fb.fb_rgb[color_slice_lo(c, k, BPP) +: BPP];
        rgb_sample[c*3+k] = comp[plane_q];
      end
    end
  end

  assign rgb_take = (state_q == ST_SHIFT) && !t_q[0] && (t_q != '0) && (t_q <= T_LAST_PIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk        <= 1'b0;
      latch       <= 1'b0;
      blank       <= 1'b1;
      rgb         <= '0;
      addry       <= '0;
      frame_start <= 1'b0;
      fb.fb_x     <= '0;
      fb.fb_y     <= '0;
    end else begin
      sclk        <= (state_q == ST_SHIFT) && t_q[0] && (t_q >= TCW'(3));
      latch       <= (state_q == ST_LATCH);
      blank       <= (state_q != ST_DISPLAY);
      frame_start <= (state_q == ST_SHIFT) && (t_q == '0) && (row_q == '0) && (plane_q == '0);
      fb.fb_y     <= row_q;
      if ((state_q == ST_SHIFT) && (t_q < T_LAST_PIX)) fb.fb_x <= XW'(t_q >> 1);
      if (rgb_take) rgb <= rgb_sample;
      // Row address only moves while dark, on the latch cycle.
      if (state_q == ST_LATCH) addry <= row_q;
    end
  end
endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Self-checking bench for hub75_bcm_scan (COLS=4, ROWS=2, CHANNELS=2, BPP=2, BASE=2).
// A frame timeline is built from the plane-period rules; each cycle the panel
// pins are compared with it, and rgb at every sclk-high cycle is checked
// against a queue of pixels predicted from the framebuffer contents.
module tb_hub75_bcm_scan;
  import hub75_pkg::*;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int CH   = 2;
  localparam int BPP  = 2;
  localparam int BASE = 2;
  localparam int PIXW = CH * 3 * BPP;
  localparam int RW   = CH * 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hub75_bcm_scan_if #(.COLS(COLS), .ROWS(ROWS), .CHANNELS(CH), .BPP(BPP)) fb_if ();

  logic [RW-1:0] rgb;
  logic          sclk, latch, blank, frame_start;
  logic [0:0]    addry;
  state_t        dbg_state;

  hub75_bcm_scan #(.COLS(COLS), .ROWS(ROWS), .CHANNELS(CH), .BPP(BPP), .BASE(BASE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fb          (fb_if.master),
    .rgb         (rgb),
    .sclk        (sclk),
    .latch       (latch),
    .blank       (blank),
    .addry       (addry),
    .frame_start (frame_start),
    .dbg_state   (dbg_state)
  );

  // registered framebuffer RAM, one-cycle read latency
  logic [PIXW-1:0] mem [ROWS][COLS];
  always @(posedge clk) fb_if.fb_rgb <= mem[fb_if.fb_y][fb_if.fb_x];

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];
  logic [0:0]    exp_addry;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // reference timeline of one frame
  typedef struct {
    bit shift;
    bit sclk;
    bit latch;
    bit blank;
    bit fs;
    int t;
    int row;
    int plane;
  } cyc_t;
  cyc_t tl[$];
  int   disp_idx[$];

  task automatic build_timeline();
    cyc_t e;
    for (int r = 0; r < ROWS; r++) begin
      for (int p = 0; p < BPP; p++) begin
        e.row = r; e.plane = p;
        for (int t = 0; t < 2 * COLS + 2; t++) begin
          e.shift = 1; e.sclk = (t >= 3) && (t % 2 == 1); e.latch = 0; e.blank = 1;
          e.fs = (t == 0) && (r == 0) && (p == 0); e.t = t;
          tl.push_back(e);
        end
        e.shift = 0; e.sclk = 0; e.latch = 1; e.blank = 1; e.fs = 0; e.t = 0;
        tl.push_back(e);
        for (int d = 0; d < (BASE << p); d++) begin
          e.latch = 0; e.blank = 0;
          disp_idx.push_back(tl.size());
          tl.push_back(e);
        end
`ifdef HUB75_GHOST_GUARD_EN
        if (p == BPP - 1) begin
          for (int g = 0; g < 2; g++) begin
            e.latch = 0; e.blank = 1;
            tl.push_back(e);
          end
        end
`endif
      end
    end
  endtask

  function automatic logic [RW-1:0] model_rgb(input int r, input int p, input int x);
    logic [RW-1:0]   v;
    logic [PIXW-1:0] px;
    px = mem[r][x];
    for (int i = 0; i < RW; i++) v[i] = px[i * BPP + p];
    return v;
  endfunction

  // mode 0: R0 of channel 0 = 2'b10 at x=2 row 0; mode 1: channel 1 B all ones; mode 2: random
  task automatic fill_mem(input int mode);
    for (int r = 0; r < ROWS; r++) begin
      for (int x = 0; x < COLS; x++) begin
        mem[r][x] = '0;
        if (mode == 0 && r == 0 && x == 2) mem[r][x] = PIXW'(2);
        if (mode == 1) for (int b = 0; b < BPP; b++) mem[r][x][5 * BPP + b] = 1'b1;
        if (mode == 2) mem[r][x] = PIXW'($urandom);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ctrl"}, {28'd0, sclk, latch, blank, frame_start}, 32'b0010);
    check_eq({tag, "_addry"}, {31'd0, addry}, 32'd0);
    check_eq({tag, "_rgb"}, {26'd0, rgb}, 32'd0);
  endtask

  // driver: reset with a fresh framebuffer pattern, release on a falling edge
  task automatic do_reset(input int mode);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_fbxy", {30'd0, fb_if.fb_y, fb_if.fb_x}, 32'd0);
    check_eq("reset_state", {30'd0, dbg_state}, {30'd0, ST_SHIFT});
    fill_mem(mode);
    exp_q.delete();
    exp_addry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_cycles(input int ncyc);
    cyc_t e;
    for (int i = 0; i < ncyc; i++) begin
      e = tl[i % tl.size()];
      @(posedge clk);
      @(negedge clk);
      check_eq("ctrl", {28'd0, sclk, latch, blank, frame_start}, {28'd0, e.sclk, e.latch, e.blank, e.fs});
      if (e.latch) exp_addry = e.row[0:0];
      check_eq("addry", {31'd0, addry}, {31'd0, exp_addry});
      if (e.shift) begin
        check_eq("fb_y", {31'd0, fb_if.fb_y}, e.row);
        if ((e.t % 2 == 0) && (e.t < 2 * COLS)) check_eq("fb_x", {30'd0, fb_if.fb_x}, e.t / 2);
      end
      if (e.sclk) exp_q.push_back(model_rgb(e.row, e.plane, (e.t - 3) / 2));
      if (sclk) begin
        check_eq("rgb_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) check_eq("rgb", {26'd0, rgb}, {26'd0, exp_q.pop_front()});
      end
    end
  endtask

  initial begin
    int fl;
    int k;
    build_timeline();
    fl = tl.size();

    // directed: single plane-1 bit at x=2
    do_reset(0);
    run_cycles(2 * fl);
    check_eq("q_empty0", exp_q.size(), 0);

    // directed: channel 1 blue saturated
    do_reset(1);
    run_cycles(2 * fl);
    check_eq("q_empty1", exp_q.size(), 0);

    // random frames with an asynchronous reset in the middle of DISPLAY
    for (int it = 0; it < 3; it++) begin
      do_reset(2);
      k = disp_idx[$urandom_range(disp_idx.size() - 1, 0)];
      run_cycles(fl + k + 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async_rst");
    end

    do_reset(2);
    run_cycles(2 * fl);
    check_eq("q_empty2", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
